div_fixed_point: RTL and testbench

DIV_FIXED_POINT -- requirements
Module: div_fixed_point

---
 rtl/fixed_point_pkg.sv | 16 +
 rtl/fxp_saturate.sv | 38 +++
 rtl/div_fixed_point.sv | 139 +++++++++++++
 tb/tb_div_fixed_point.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and divider state encoding.
// Defaults describe the Q7.8 format used at DATA_WIDTH = 16.
package fixed_point_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned FRAC_BITS      = DEF_DATA_WIDTH / 2;
    localparam logic [DEF_DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DEF_DATA_WIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/fxp_saturate.sv
// Signed saturation of an unsigned magnitude plus sign into a WIDTH-bit two's complement value.
// Shared between the divider and multiplier result paths.
module fxp_saturate #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MAG_W = 24
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             sign,
    output logic [WIDTH-1:0] res_c,
    output logic             ovf_c
);

    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] low;

    // Negative side may reach one step further than the positive side.
    always_comb begin
        low   = mag[WIDTH-1:0];
        ovf_c = 1'b0;
        res_c = low;
        if (sign) begin
            if (mag > NEG_LIM) begin
                res_c = OUT_MIN;
                ovf_c = 1'b1;
            end else begin
                res_c = -low;
            end
        end else if (mag > POS_LIM) begin
            res_c = OUT_MAX;
            ovf_c = 1'b1;
        end
    end

endmodule

// File: rtl/div_fixed_point.sv
// Signed fixed-point divider, restoring algorithm, one quotient bit per cycle.
// Define DIV_FIXED_POINT_ROUND_EN for round-half-away-from-zero; default truncates.
module div_fixed_point
    import fixed_point_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  C,
    output logic                  N,
    output logic                  V,
    output logic                  Z
);

    localparam int unsigned FRAC  = DATA_WIDTH / 2;
    localparam int unsigned DIV_W = DATA_WIDTH + FRAC;
    localparam int unsigned CNT_W = $clog2(DIV_W);
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t            state;
    logic [CNT_W-1:0]      count;
    logic                  sign;
    logic                  a_neg;
    logic                  div0;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DIV_W-1:0]      dividend;
    logic [DATA_WIDTH:0]   rem;
    logic [DIV_W-1:0]      quo;

    logic                  accept;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH:0]   trial;
    logic                  ge;
    logic [DATA_WIDTH:0]   rem_next;
    logic [DIV_W-1:0]      mag;
    logic [DATA_WIDTH-1:0] sat_res;
    logic                  sat_ovf;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_v;

    // One restoring step plus final magnitude/result selection.
    always_comb begin
        accept   = (state == IDLE) && start && !busy;
        a_mag    = A[DATA_WIDTH-1] ? -A : A;
        trial    = (DATA_WIDTH+1)'({rem, dividend[DIV_W-1]});
        ge       = trial >= {1'b0, b_mag};
        rem_next = ge ? trial - {1'b0, b_mag} : trial;
`ifdef DIV_FIXED_POINT_ROUND_EN
        mag      = quo + DIV_W'({rem, 1'b0} >= (DATA_WIDTH+2)'(b_mag));
`else
        mag      = quo;
`endif
        result   = div0 ? (a_neg ? OUT_MIN : OUT_MAX) : sat_res;
        result_v = div0 | sat_ovf;
    end

    fxp_saturate #(
        .WIDTH (DATA_WIDTH),
        .MAG_W (DIV_W)
    ) u_sat (
        .mag   (mag),
        .sign  (sign),
        .res_c (sat_res),
        .ovf_c (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            sign     <= 1'b0;
            a_neg    <= 1'b0;
            div0     <= 1'b0;
            b_mag    <= '0;
            dividend <= '0;
            rem      <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Out      <= '0;
            N        <= 1'b0;
            V        <= 1'b0;
            Z        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        sign     <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
                        a_neg    <= A[DATA_WIDTH-1];
                        div0     <= (B == '0);
                        b_mag    <= B[DATA_WIDTH-1] ? -B : B;
                        dividend <= {a_mag, FRAC'(0)};
                        rem      <= '0;
                        quo      <= '0;
                        count    <= '0;
                        state    <= (B == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    busy     <= 1'b1;
                    rem      <= rem_next;
                    quo      <= {quo[DIV_W-2:0], ge};
                    dividend <= dividend << 1;
                    count    <= count + CNT_W'(1);
                    if (count == CNT_W'(DIV_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through the done pulse cycle
                    busy  <= 1'b1;
                    done  <= 1'b1;
                    Out   <= result;
                    N     <= result[DATA_WIDTH-1];
                    V     <= result_v;
                    Z     <= (result == '0);
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign C = 1'b0;

endmodule

// File: tb/tb_div_fixed_point.sv
// Directed-vector bench for div_fixed_point at DATA_WIDTH = 16 (Q7.8).
module tb_div_fixed_point;
    import fixed_point_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Out;
    logic        C;
    logic        N;
    logic        V;
    logic        Z;

    int n_vec;
    int n_err;

`ifdef DIV_FIXED_POINT_ROUND_EN
    localparam logic [15:0] TWO_THIRDS = 16'h00AB;
`else
    localparam logic [15:0] TWO_THIRDS = 16'h00AA;
`endif

    div_fixed_point #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Out   (Out),
        .C     (C),
        .N     (N),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one division and check result, flags, latency, busy window and pulse width.
    task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_out, input logic exp_v, input int exp_lat);
        int lat;
        int bc;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
        check($sformatf("lat %h/%h", a, b), 32'(lat), 32'(exp_lat));
        check($sformatf("out %h/%h", a, b), 32'(Out), 32'(exp_out));
        check($sformatf("v %h/%h", a, b), 32'(V), 32'(exp_v));
        check($sformatf("n %h/%h", a, b), 32'(N), 32'(exp_out[15]));
        check($sformatf("z %h/%h", a, b), 32'(Z), 32'(exp_out == 16'h0000));
        check($sformatf("c %h/%h", a, b), 32'(C), 32'h0);
        @(posedge clk); #1;
        if (busy) bc++;
        check($sformatf("pulse %h/%h", a, b), 32'(done), 32'h0);
        check($sformatf("busy %h/%h", a, b), 32'(bc), 32'(exp_lat + 1));
        check($sformatf("hold %h/%h", a, b), 32'(Out), 32'(exp_out));
    endtask

    initial begin
        int dones;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst out",  32'(Out),  32'h0);
        check("rst z",    32'(Z),    32'h1);
        check("rst nvc",  32'({N, V, C}), 32'h0);
        rst_n = 1'b1;

        run_vec(16'h0600, 16'h0200, 16'h0300, 1'b0, 25);
        run_vec(16'hFE80, 16'h0080, 16'hFD00, 1'b0, 25);
        run_vec(16'h8000, 16'h0100, Q_MIN,    1'b0, 25);
        run_vec(16'h6400, 16'h0040, Q_MAX,    1'b1, 25);
        run_vec(16'h0100, 16'h0000, Q_MAX,    1'b1, 1);
        run_vec(16'h8000, 16'h0000, Q_MIN,    1'b1, 1);
        run_vec(16'h0200, 16'h0300, TWO_THIRDS, 1'b0, 25);
        run_vec(16'h0000, 16'h0500, 16'h0000, 1'b0, 25);
        run_vec(16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 25);
        run_vec(16'h8000, 16'h0080, Q_MIN,    1'b1, 25);
        run_vec(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 25);
        run_vec(16'h7FFF, 16'h0100, Q_MAX,    1'b0, 25);

        // Second start while busy must be ignored.
        @(negedge clk);
        A = 16'h0600; B = 16'h0200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        A = 16'h0100; B = 16'h0000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                check("ignore out", 32'(Out), 32'h0300);
            end
        end
        check("ignore dones", 32'(dones), 32'h1);

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        A = 16'h0200; B = 16'h0300; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; #1;
        check("abort busy", 32'(busy), 32'h0);
        check("abort out",  32'(Out),  32'h0);
        check("abort z",    32'(Z),    32'h1);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort dones", 32'(dones), 32'h0);
        run_vec(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
